// File: rtl/seg7_scan_if.sv
// Scanned 7-segment display bus as seen by the receive-side decoder.
// master: display driver / bench side; slave: seg7_scan_decoder.
interface seg7_scan_if;
  logic [3:0] an;
  logic [6:0] dout;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] dig_valid;
  logic       pat_err;
  logic       frame_done;
  logic       order_err;

  modport master (
    output an,
    output dout,
    input  dig0,
    input  dig1,
    input  dig2,
    input  dig3,
    input  dig_valid,
    input  pat_err,
    input  frame_done,
    input  order_err
  );

  modport slave (
    input  an,
    input  dout,
    output dig0,
    output dig1,
    output dig2,
    output dig3,
    output dig_valid,
    output pat_err,
    output frame_done,
    output order_err
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 4-digit active-low display bus, filters scan glitches and decodes each digit.
// Optional scan-order checking is enabled by defining SEG7_SCAN_ORDER_CHECK_EN.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);

  localparam int unsigned StW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [StW-1:0]  StCapture = StW'(STABLE_CYCLES - 1);
  localparam logic [StW-1:0]  StMax     = StW'(STABLE_CYCLES);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax    = TmoW'(TIMEOUT_CYCLES);

  // Sample layout: {an[3:0], dout[6:0]}
  logic [10:0]     r_sync1;
  logic [10:0]     r_sync2;
  logic [10:0]     r_prev;
  logic [StW-1:0]  r_stab_cnt;
  logic [TmoW-1:0] r_tmo [4];
  logic [3:0]      r_dig [4];
  logic [3:0]      r_valid;
  logic [3:0]      r_mask;
  logic            r_pat_err;
  logic            r_frame_done;

  logic            w_same;
  logic            w_one_low;
  logic            w_capture;
  logic [1:0]      w_idx;
  logic [6:0]      w_seg;
  logic [4:0]      w_dec;
  logic            w_hit;
  logic [3:0]      w_val;
  logic            w_blank;
  logic            w_match;
  logic            w_dash;
  logic            w_bad;
  logic [3:0]      w_seen;

  function automatic logic one_low(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  // Returns {hit, value} for an active-high segment pattern.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b0111111: decode_glyph = {1'b1, 4'h0};
      7'b0000110: decode_glyph = {1'b1, 4'h1};
      7'b1011011: decode_glyph = {1'b1, 4'h2};
      7'b1001111: decode_glyph = {1'b1, 4'h3};
      7'b1100110: decode_glyph = {1'b1, 4'h4};
      7'b1101101: decode_glyph = {1'b1, 4'h5};
      7'b1111101: decode_glyph = {1'b1, 4'h6};
      7'b0000111: decode_glyph = {1'b1, 4'h7};
      7'b1111111: decode_glyph = {1'b1, 4'h8};
      7'b1101111: decode_glyph = {1'b1, 4'h9};
      7'b1110111: decode_glyph = {1'b1, 4'hA};
      7'b1111100: decode_glyph = {1'b1, 4'hB};
      7'b0111001: decode_glyph = {1'b1, 4'hC};
      7'b1011110: decode_glyph = {1'b1, 4'hD};
      7'b1111001: decode_glyph = {1'b1, 4'hE};
      7'b1110001: decode_glyph = {1'b1, 4'hF};
      default:    decode_glyph = 5'b0_0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {bus.an, bus.dout};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_same    = (r_sync2 == r_prev);
  assign w_one_low = one_low(r_sync2[10:7]);

  // A nonzero count implies r_prev carries a single-digit select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab_cnt <= '0;
    end else if (!w_same || !w_one_low) begin
      r_stab_cnt <= '0;
    end else if (r_stab_cnt != StMax) begin
      r_stab_cnt <= r_stab_cnt + StW'(1);
    end
  end

  assign w_capture = (r_stab_cnt == StCapture);

  always_comb begin
    w_idx = 2'd0;
    case (r_prev[10:7])
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  assign w_seg   = ~r_prev[6:0];
  assign w_dec   = decode_glyph(w_seg);
  assign w_hit   = w_dec[4];
  assign w_val   = w_dec[3:0];
  assign w_blank = (w_seg == 7'b0000000) || (w_seg == 7'b1000000);
  assign w_match = w_capture && w_hit;
  assign w_dash  = w_capture && !w_hit && w_blank;
  assign w_bad   = w_capture && !w_hit && !w_blank;
  assign w_seen  = (w_match || w_dash) ? (4'b0001 << w_idx) : 4'b0000;

  // A capture for a digit takes priority over that digit's timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        r_dig[n] <= '0;
        r_tmo[n] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_match && (w_idx == 2'(n))) begin
          r_dig[n]   <= w_val;
          r_valid[n] <= 1'b1;
          r_tmo[n]   <= '0;
        end else begin
          if (r_tmo[n] != TmoMax) begin
            r_tmo[n] <= r_tmo[n] + TmoW'(1);
          end
          if ((r_tmo[n] >= TmoLast) || (w_dash && (w_idx == 2'(n)))) begin
            r_valid[n] <= 1'b0;
          end
        end
      end
    end
  end

  // The mask restarts on the frame_done edge but still records a capture landing there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask       <= '0;
      r_frame_done <= 1'b0;
      r_pat_err    <= 1'b0;
    end else begin
      r_pat_err <= w_bad;
      if (r_mask == 4'b1111) begin
        r_frame_done <= 1'b1;
        r_mask       <= w_seen;
      end else begin
        r_frame_done <= 1'b0;
        r_mask       <= r_mask | w_seen;
      end
    end
  end

`ifdef SEG7_SCAN_ORDER_CHECK_EN
  logic [1:0] r_last_idx;
  logic       r_order_err;

  // Every capture, including a bad pattern, advances the expected scan position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_idx  <= 2'd3;
      r_order_err <= 1'b0;
    end else if (w_capture) begin
      r_order_err <= (w_idx != (r_last_idx + 2'd1));
      r_last_idx  <= w_idx;
    end else begin
      r_order_err <= 1'b0;
    end
  end

  assign bus.order_err = r_order_err;
`else
  assign bus.order_err = 1'b0;
`endif

  assign bus.dig0       = r_dig[0];
  assign bus.dig1       = r_dig[1];
  assign bus.dig2       = r_dig[2];
  assign bus.dig3       = r_dig[3];
  assign bus.dig_valid  = r_valid;
  assign bus.pat_err    = r_pat_err;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scanning against a history-based model.
module tb_seg7_scan_decoder;
  localparam int S = 4;
  localparam int T = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if bus ();

  seg7_scan_decoder #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cnt_pe = 0;
  int cnt_fd = 0;
  int cnt_oe = 0;

  logic [6:0]  glyph [16];
  logic [10:0] hist [S+4];  // hist[0] = pins seen by the latest edge
  logic [3:0]  m_dig [4];
  logic [3:0]  m_val;
  logic [3:0]  m_mask;
  logic        m_pe, m_fd, m_oe;
  int          m_last;
  int          m_age [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S + 4; i++) hist[i] = '0;
    for (int n = 0; n < 4; n++) begin
      m_dig[n] = '0;
      m_age[n] = 0;
    end
    m_val = '0; m_mask = '0; m_pe = 0; m_fd = 0; m_oe = 0; m_last = 3;
  endtask

  // A capture lands on edge k when pins seen at edges k-S-2..k-3 are identical,
  // one digit is selected, and the pins at edge k-S-3 differed.
  task automatic model_step();
    logic [10:0] c;
    logic [6:0]  seg;
    logic [3:0]  v;
    bit          run, cap, hit, blank;
    int          zeros, idx;
    for (int i = S + 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {bus.an, bus.dout};
    c = hist[3];
    run = 1;
    for (int i = 4; i <= S + 2; i++) if (hist[i] != c) run = 0;
    if (hist[S+3] == c) run = 0;
    zeros = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!c[7+i]) begin zeros++; idx = i; end
    cap = run && (zeros == 1);
    seg = ~c[6:0];
    hit = 0; v = '0;
    for (int g = 0; g < 16; g++) if (!hit && glyph[g] == seg) begin hit = 1; v = 4'(g); end
    blank = (seg == 7'h00) || (seg == 7'h40);
    m_pe = cap && !hit && !blank;
    m_fd = (m_mask == 4'hF);
    if (m_fd) m_mask = '0;
    if (cap && (hit || blank)) m_mask[idx] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (cap && hit && idx == n) begin
        m_dig[n] = v; m_val[n] = 1'b1; m_age[n] = 0;
      end else begin
        if (m_age[n] < T) m_age[n]++;
        if (m_age[n] == T) m_val[n] = 1'b0;
        if (cap && blank && idx == n) m_val[n] = 1'b0;
      end
    end
`ifdef SEG7_SCAN_ORDER_CHECK_EN
    m_oe = cap && (idx != (m_last + 1) % 4);
    if (cap) m_last = idx;
`else
    m_oe = 0;
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare and pulse monitor, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("dig0", bus.dig0, m_dig[0]);
        chk("dig1", bus.dig1, m_dig[1]);
        chk("dig2", bus.dig2, m_dig[2]);
        chk("dig3", bus.dig3, m_dig[3]);
        chk("dig_valid", bus.dig_valid, m_val);
        chk("pat_err", bus.pat_err, m_pe);
        chk("frame_done", bus.frame_done, m_fd);
        chk("order_err", bus.order_err, m_oe);
        if (bus.pat_err) cnt_pe++;
        if (bus.frame_done) cnt_fd++;
        if (bus.order_err) cnt_oe++;
      end
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] seg, input int n);
    bus.an = a;
    bus.dout = ~seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic random_phase(input int segs);
    logic [3:0] a;
    logic [6:0] seg;
    int r;
    for (int i = 0; i < segs; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = ~(4'(1) << $urandom_range(0, 3));
      else if (r == 8) a = 4'hF;
      else a = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7) seg = glyph[$urandom_range(0, 15)];
      else if (r == 7) seg = 7'h40;
      else if (r == 8) seg = 7'h00;
      else seg = 7'($urandom);
      hold(a, seg, $urandom_range(1, 10));
    end
  endtask

  logic [3:0] scan_val [4];
  logic [3:0] a_sel;

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    scan_val = '{4'h1, 4'hA, 4'hD, 4'h7};
    bus.an = 4'hF;
    bus.dout = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.dig_valid, 4'h0);
    chk("rst_dig3", bus.dig3, 4'h0);
    chk("rst_frame", bus.frame_done, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Idle blanking
    hold(4'hF, 7'h00, 100);
    chk("idle_valid", bus.dig_valid, 4'h0);
    chk("idle_dig0", bus.dig0, 4'h0);
    chk("idle_pe", cnt_pe, 0);
    chk("idle_fd", cnt_fd, 0);

    // Latency: capture visible on edge S+3
    bus.an = 4'hE;
    bus.dout = ~glyph[2];
    repeat (S + 2) @(negedge clk);
    chk("lat_before", bus.dig_valid, 4'h0);
    @(negedge clk);
    chk("lat_dig0", bus.dig0, 4'h2);
    chk("lat_valid", bus.dig_valid, 4'h1);
    repeat (3) @(negedge clk);

    // Glitching input never settles long enough
    for (int i = 0; i < 5; i++) begin
      hold(4'hE, glyph[5], 2);
      hold(4'hE, glyph[9], 2);
    end
    chk("glitch_dig0", bus.dig0, 4'h2);
    chk("glitch_pe", cnt_pe, 0);
    hold(4'hE, glyph[15], 10);
    chk("glitch_F", bus.dig0, 4'hF);

    // Two full scans, one frame_done each
    for (int rep = 0; rep < 2; rep++) begin
      cnt_fd = 0;
      for (int d = 0; d < 4; d++) begin
        a_sel = ~(4'(1) << d);
        hold(a_sel, glyph[scan_val[d]], 8);
      end
      hold(4'hF, 7'h00, 10);
      chk("scan_fd", cnt_fd, 1);
    end
    chk("scan_dig0", bus.dig0, 4'h1);
    chk("scan_dig1", bus.dig1, 4'hA);
    chk("scan_dig2", bus.dig2, 4'hD);
    chk("scan_dig3", bus.dig3, 4'h7);
    chk("scan_valid", bus.dig_valid, 4'hF);

    // Illegal pattern, then dash
    cnt_pe = 0;
    hold(4'hD, 7'h01, 10);
    chk("bad_pe", cnt_pe, 1);
    chk("bad_dig1", bus.dig1, 4'hA);
    chk("bad_valid1", bus.dig_valid[1], 1'b1);
    cnt_pe = 0;
    hold(4'hD, 7'h40, 10);
    chk("dash_valid1", bus.dig_valid[1], 1'b0);
    chk("dash_pe", cnt_pe, 0);

    // Timeout: capture on edge S+3, valid drops T edges later
    bus.an = 4'hB;
    bus.dout = ~glyph[5];
    repeat (S + 3) @(negedge clk);
    chk("tmo_dig2", bus.dig2, 4'h5);
    chk("tmo_cap", bus.dig_valid[2], 1'b1);
    bus.an = 4'hF;
    repeat (T - 1) @(negedge clk);
    chk("tmo_hold", bus.dig_valid[2], 1'b1);
    @(negedge clk);
    chk("tmo_drop", bus.dig_valid[2], 1'b0);
    chk("tmo_held_dig2", bus.dig2, 4'h5);

    // Scan order 3,0,2 after a digit-2 capture
    cnt_oe = 0;
    hold(4'h7, glyph[1], 8);
    hold(4'hE, glyph[2], 8);
    hold(4'hB, glyph[3], 8);
    hold(4'hF, 7'h00, 4);
`ifdef SEG7_SCAN_ORDER_CHECK_EN
    chk("order_cnt", cnt_oe, 1);
`else
    chk("order_cnt", cnt_oe, 0);
`endif

    random_phase(500);

    // Asynchronous reset mid-operation
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.dig_valid, 4'h0);
    chk("arst_dig0", bus.dig0, 4'h0);
    chk("arst_pe", bus.pat_err, 1'b0);
    chk("arst_fd", bus.frame_done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    random_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
